// File: rtl/cordic_vec_arb.sv
// cordic_vec_arb
// Round-robin arbiter and sequencer sharing one fully pipelined CORDIC
// vectoring core among N requesters. One request is accepted per cycle;
// its operands are registered onto core_x/core_y. The requester index
// travels alongside the operation through a tag pipeline, and each phase
// result is routed back as a one-cycle one-hot strobe.
//
// Core timing: the core_x/core_y register is the core's input stage.
// core_phase for an operation accepted in cycle T must be valid during
// cycle T+CORE_LAT. It is registered, so the result appears in T+CORE_LAT+1.
//
// Optional feature (macro CORDIC_ARB_QUAD_EN): quadrant fold. Operands
// with x<0 are negated before entering the core. The output is then
// corrected by +/-180 degrees, which gives a full +/-180 degree range.
// Without the macro, operands pass unmodified and results are meaningful
// only for x>0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                grant enable
//   req_valid[N]      request valid per requester
//   req_ready[N]      grant, one-hot or zero (combinational)
//   req_x/req_y       packed operands, requester i at [i*W +: W]
//   core_x/core_y     registered operands to the core (0 on bubbles)
//   core_phase        core result, degrees * 2^16
//   res_valid[N]      one-hot result strobe
//   res_tag           requester index of the current result (holds)
//   res_phase         phase result (holds when no result is valid)
//   busy              any operation in flight or being accepted
module cordic_vec_arb #(
   parameter int N        = 4,
   parameter int W        = 32,
   parameter int CORE_LAT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N-1:0]           req_valid,
   output logic [N-1:0]           req_ready,
   input  logic [N*W-1:0]         req_x,
   input  logic [N*W-1:0]         req_y,
   output logic [W-1:0]           core_x,
   output logic [W-1:0]           core_y,
   input  logic [W-1:0]           core_phase,
   output logic [N-1:0]           res_valid,
   output logic [$clog2(N)-1:0]   res_tag,
   output logic [W-1:0]           res_phase,
   output logic                   busy
);

   localparam int IDX_W = $clog2(N);

   // Decode a requester index into a one-hot vector.
   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] v;
      v = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         v[i] = (idx == IDX_W'(i));
      end
      return v;
   endfunction

   // (base + off) mod N, for off in 0..N-1.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      s = (s >= N) ? (s - N) : s;
      return IDX_W'(s);
   endfunction

   logic [IDX_W-1:0]  rr_ptr_r;
   logic              grant_any_s;
   logic [IDX_W-1:0]  grant_idx_s;
   logic [W-1:0]      sel_x_s;
   logic [W-1:0]      sel_y_s;
   logic [W-1:0]      drv_x_s;
   logic [W-1:0]      drv_y_s;
   logic [W-1:0]      phase_fix_s;
   // Valid bits run one stage past the idx stages, so busy covers the
   // cycle in which the result is being presented.
   logic [CORE_LAT:0] tag_vld_r;
   logic [IDX_W-1:0]  tag_idx_r [CORE_LAT];
`ifdef CORDIC_ARB_QUAD_EN
   localparam logic [W-1:0] HALF_TURN = W'(32'd11796480);
   logic                fold_s;
   logic                ysgn_s;
   logic [CORE_LAT-1:0] tag_fold_r;
   logic [CORE_LAT-1:0] tag_ysgn_r;
`endif

   // Round-robin grant: the first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = {IDX_W{1'b0}};
      for (int k = 0; k < N; k++) begin
         logic hit;
         hit = en && !grant_any_s && req_valid[wrap_idx(rr_ptr_r, k)];
         grant_idx_s = hit ? wrap_idx(rr_ptr_r, k) : grant_idx_s;
         grant_any_s = grant_any_s | hit;
      end
      req_ready = grant_any_s ? onehot(grant_idx_s) : {N{1'b0}};
   end

   // Operand select and optional quadrant fold.
   always_comb begin
      sel_x_s = req_x[grant_idx_s*W +: W];
      sel_y_s = req_y[grant_idx_s*W +: W];
`ifdef CORDIC_ARB_QUAD_EN
      fold_s  = sel_x_s[W-1];
      ysgn_s  = sel_y_s[W-1];
      drv_x_s = fold_s ? -sel_x_s : sel_x_s;
      drv_y_s = fold_s ? -sel_y_s : sel_y_s;
`else
      drv_x_s = sel_x_s;
      drv_y_s = sel_y_s;
`endif
   end

   // Output phase correction. A folded operand sits 180 degrees away from
   // the core's answer; the sign of the original y picks the direction.
   always_comb begin
`ifdef CORDIC_ARB_QUAD_EN
      if (tag_fold_r[CORE_LAT-1]) begin
         phase_fix_s = tag_ysgn_r[CORE_LAT-1] ? (core_phase - HALF_TURN)
                                               : (core_phase + HALF_TURN);
      end else begin
         phase_fix_s = core_phase;
      end
`else
      phase_fix_s = core_phase;
`endif
   end

   // busy covers anything in the tag pipe plus an accept in this cycle.
   always_comb begin
      busy = (|tag_vld_r) | grant_any_s;
   end

   // Core operand register, round-robin pointer, tag pipeline and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r  <= {IDX_W{1'b0}};
         core_x    <= {W{1'b0}};
         core_y    <= {W{1'b0}};
         tag_vld_r <= {(CORE_LAT+1){1'b0}};
         for (int j = 0; j < CORE_LAT; j++) begin
            tag_idx_r[j] <= {IDX_W{1'b0}};
         end
`ifdef CORDIC_ARB_QUAD_EN
         tag_fold_r <= {CORE_LAT{1'b0}};
         tag_ysgn_r <= {CORE_LAT{1'b0}};
`endif
         res_valid <= {N{1'b0}};
         res_tag   <= {IDX_W{1'b0}};
         res_phase <= {W{1'b0}};
      end else begin
         if (grant_any_s) begin
            core_x   <= drv_x_s;
            core_y   <= drv_y_s;
            rr_ptr_r <= wrap_idx(grant_idx_s, 1);
         end else begin
            // Bubbles present zero operands so the core never sees stale data.
            core_x   <= {W{1'b0}};
            core_y   <= {W{1'b0}};
            rr_ptr_r <= rr_ptr_r;
         end

         // The pipe shifts unconditionally; the core cannot stall.
         tag_vld_r    <= {tag_vld_r[CORE_LAT-1:0], grant_any_s};
         tag_idx_r[0] <= grant_idx_s;
         for (int j = 1; j < CORE_LAT; j++) begin
            tag_idx_r[j] <= tag_idx_r[j-1];
         end
`ifdef CORDIC_ARB_QUAD_EN
         tag_fold_r <= {tag_fold_r[CORE_LAT-2:0], fold_s};
         tag_ysgn_r <= {tag_ysgn_r[CORE_LAT-2:0], ysgn_s};
`endif

         if (tag_vld_r[CORE_LAT-1]) begin
            res_valid <= onehot(tag_idx_r[CORE_LAT-1]);
            res_tag   <= tag_idx_r[CORE_LAT-1];
            res_phase <= phase_fix_s;
         end else begin
            res_valid <= {N{1'b0}};
            res_tag   <= res_tag;
            res_phase <= res_phase;
         end
      end
   end

endmodule

// File: tb/tb_cordic_vec_arb.sv
// Self-checking bench for cordic_vec_arb. Contains a behavioural CORDIC core
// stand-in: real atan2 applied to the core operands after the core latency.
// The reference model expects atan2 of the original operands, with each
// result due LAT+1 cycles after its accept.
module tb_cordic_vec_arb;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 16;
   localparam int TOL = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, en;
   logic [N-1:0]   req_valid, req_ready, res_valid;
   logic [N*W-1:0] req_x, req_y;
   logic [W-1:0]   core_x, core_y, core_phase, res_phase;
   logic [1:0]     res_tag;
   logic           busy;

   cordic_vec_arb #(.N(N), .W(W), .CORE_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .en(en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y),
      .core_x(core_x), .core_y(core_y), .core_phase(core_phase),
      .res_valid(res_valid), .res_tag(res_tag), .res_phase(res_phase),
      .busy(busy)
   );

   function automatic int phase_of(input int x, input int y);
      real d;
      if (x == 0 && y == 0) return 0;
      d = $atan2($itor(y), $itor(x)) * 180.0 / 3.14159265358979 * 65536.0;
      return $rtoi(d + ((d >= 0.0) ? 0.5 : -0.5));
   endfunction

   // Core stand-in: the DUT's core_x register is stage 1, so add LAT-1 stages.
   int cx_q [LAT-1];
   int cy_q [LAT-1];
   always @(posedge clk) begin
      cx_q[0] <= int'(core_x);
      cy_q[0] <= int'(core_y);
      for (int k = 1; k < LAT-1; k++) begin
         cx_q[k] <= cx_q[k-1];
         cy_q[k] <= cy_q[k-1];
      end
   end
   always_comb core_phase = phase_of(cx_q[LAT-2], cy_q[LAT-2]);

   typedef struct { int due; int idx; int ph; } exp_t;
   exp_t q[$];
   int   rr, cyc, last_tag, last_ph, exp_cx, exp_cy;
   int   ox[N], oy[N];
   int   checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int exp);
      checks++;
      assert ((obs - exp) <= TOL && (exp - obs) <= TOL) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rnd_signed();
      return int'($urandom_range(0, 32'h7fff_ffff)) - 1073741824;
   endfunction

   // One clock: drive, check against the model, then advance the model over the edge.
   task automatic cycle(input logic rst_v, input logic en_v, input logic [N-1:0] v);
      int   g;
      exp_t e;
      rst = rst_v; en = en_v; req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_x[i*W +: W] = ox[i];
         req_y[i*W +: W] = oy[i];
      end
      #1;
      g = -1;
      if (en_v) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
         end
      end
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("busy", 32'(busy), 32'((g >= 0) || (q.size() > 0)));
      chk("core_x", core_x, exp_cx);
      chk("core_y", core_y, exp_cy);
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("res_valid", 32'(res_valid), 32'd1 << e.idx);
         chk("res_tag", 32'(res_tag), e.idx);
         chk_near("res_phase", int'($signed(res_phase)), e.ph);
         last_tag = e.idx;
         last_ph  = e.ph;
      end else begin
         chk("res_valid_idle", 32'(res_valid), 32'd0);
         chk("res_tag_hold", 32'(res_tag), last_tag);
         chk_near("res_phase_hold", int'($signed(res_phase)), last_ph);
      end
      if (rst_v) begin
         q.delete();
         rr = 0; exp_cx = 0; exp_cy = 0; last_tag = 0; last_ph = 0;
      end else if (g >= 0) begin
         q.push_back('{cyc + LAT + 1, g, phase_of(ox[g], oy[g])});
         rr = (g + 1) % N;
         exp_cx = ox[g]; exp_cy = oy[g];
`ifdef CORDIC_ARB_QUAD_EN
         if (ox[g] < 0) begin exp_cx = -ox[g]; exp_cy = -oy[g]; end
`endif
      end else begin
         exp_cx = 0; exp_cy = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < N; i++) begin
`ifdef CORDIC_ARB_QUAD_EN
         ox[i] = rnd_signed();
`else
         ox[i] = int'($urandom_range(1, 32'h4000_0000));
`endif
         oy[i] = rnd_signed();
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
      for (int i = 0; i < N; i++) begin ox[i] = 0; oy[i] = 0; end
      rr = 0; cyc = 0; last_tag = 0; last_ph = 0; exp_cx = 0; exp_cy = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state, then a single request from requester 2 at 45 degrees.
      cycle(1'b1, 1'b0, 4'b0000);
      cycle(1'b0, 1'b1, 4'b0000);
      ox[2] = 65536; oy[2] = 65536;
      cycle(1'b0, 1'b1, 4'b0100);
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      // Round-robin from rr_ptr=0, all requesters continuously valid.
      cycle(1'b1, 1'b0, 4'b0000);
      for (int n = 0; n < 12; n++) begin
         randomize_ops();
         cycle(1'b0, 1'b1, 4'b1111);
      end
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      // Gating: en low blocks all grants, then requester 0 goes first.
      repeat (3) cycle(1'b0, 1'b0, 4'b1111);
      randomize_ops();
      cycle(1'b0, 1'b1, 4'b1111);
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      // Reset mid-flight: three accepts, reset five cycles later, no results.
      for (int n = 0; n < 3; n++) begin
         randomize_ops();
         cycle(1'b0, 1'b1, 4'b1111);
      end
      repeat (4) cycle(1'b0, 1'b1, 4'b0000);
      cycle(1'b1, 1'b1, 4'b0000);
      repeat (LAT + 5) cycle(1'b0, 1'b1, 4'b0000);
      randomize_ops();
      cycle(1'b0, 1'b1, 4'b1111);
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      // Randomised traffic with random enable and request patterns.
      for (int n = 0; n < 300; n++) begin
         randomize_ops();
         cycle(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      // Directed corners: -45 degrees, plus negative-x quadrants when folding.
      ox[1] = 65536; oy[1] = -65536;
      cycle(1'b0, 1'b1, 4'b0010);
`ifdef CORDIC_ARB_QUAD_EN
      ox[0] = -65536; oy[0] = 65536;
      ox[1] = -65536; oy[1] = -65536;
      ox[2] = -65536; oy[2] = 0;
      repeat (3) cycle(1'b0, 1'b1, 4'b0111);
`endif
      repeat (LAT + 3) cycle(1'b0, 1'b1, 4'b0000);

      chk("drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
